// File: rtl/prelude_alu_pkg.sv
// prelude_alu_pkg: opcode and state enums, flag bit positions and flag packing shared by alu_mc.
package prelude_alu_pkg;

    typedef enum logic [5:0] {
        OP_OR   = 6'd0,
        OP_NAND = 6'd1,
        OP_NOR  = 6'd2,
        OP_AND  = 6'd3,
        OP_ADD  = 6'd4,
        OP_SUB  = 6'd5,
        OP_XOR  = 6'd6,
        OP_SHL  = 6'd7,
        OP_SHR  = 6'd8,
        OP_SRA  = 6'd9,
        OP_MUL  = 6'd10
    } alu_op_e;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [3:0] pack_flags(input logic z, input logic n, input logic c, input logic v);
        logic [3:0] f;
        f = '0;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one partial product per cycle for WIDTH cycles.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CW = $clog2(WIDTH);

    logic               busy_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     sum;

    // Low half of the accumulator starts as the multiplier and drains out as the product shifts in.
    always_comb begin
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? a_q : {WIDTH{1'b0}}};
        acc_d = {sum, acc_q[WIDTH-1:1]};
    end

    assign done_o    = busy_q && cnt_q == CW'(WIDTH - 1);
    assign product_o = acc_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            a_q    <= a_i;
            acc_q  <= {{WIDTH{1'b0}}, b_i};
        end else if (busy_q) begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_q + 1'b1;
            busy_q <= !done_o;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with registered result/flags and valid/ready handshakes.
// Define PRELUDE_ALU_MUL_EN to build the iterative MUL; otherwise opcode MUL is treated as unknown.
module alu_mc
    import prelude_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OP_W  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic [3:0]       flags
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     out_q, out_d, hi_q, hi_d, res;
    logic [3:0]           flags_q, flags_d;
    logic [WIDTH:0]       sum, diff;
    logic                 c, v, accept, is_mul, mul_done;
    logic [2*WIDTH-1:0]   prod;

    always_comb begin
        sum  = {1'b0, in_a} + {1'b0, in_b};
        diff = {1'b0, in_a} - {1'b0, in_b};
        res  = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (alu_op)
            OP_OR:   res = in_a | in_b;
            OP_NAND: res = ~(in_a & in_b);
            OP_NOR:  res = ~(in_a | in_b);
            OP_AND:  res = in_a & in_b;
            OP_ADD: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (res[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff[WIDTH-1:0];
                c   = diff[WIDTH];
                v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (res[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_XOR:  res = in_a ^ in_b;
            // Oversized shift amounts fall out of the language semantics: zero fill, or sign fill for >>>.
            OP_SHL:  res = in_a << in_b;
            OP_SHR:  res = in_a >> in_b;
            OP_SRA:  res = $unsigned($signed(in_a) >>> in_b);
            default: res = '0;
        endcase
    end

`ifdef PRELUDE_ALU_MUL_EN
    assign is_mul = alu_op == OP_MUL;
    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (accept && is_mul),
        .a_i       (in_a),
        .b_i       (in_b),
        .done_o    (mul_done),
        .product_o (prod)
    );
`else
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
    assign prod     = '0;
`endif

    assign in_ready = state_q == IDLE || (state_q == DONE && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        hi_d    = hi_q;
        flags_d = flags_q;
        if (accept) begin
            state_d = is_mul ? BUSY : DONE;
            if (!is_mul) begin
                out_d   = res;
                hi_d    = '0;
                flags_d = pack_flags(res == '0, res[WIDTH-1], c, v);
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end else if (mul_done) begin
            state_d = DONE;
            out_d   = prod[WIDTH-1:0];
            hi_d    = prod[2*WIDTH-1:WIDTH];
            flags_d = pack_flags(prod[WIDTH-1:0] == '0, prod[WIDTH-1], |prod[2*WIDTH-1:WIDTH], 1'b0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            out_q   <= '0;
            hi_q    <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            hi_q    <= hi_d;
            flags_q <= flags_d;
        end
    end

    assign out_valid = state_q == DONE;
    assign out       = out_q;
    assign out_hi    = hi_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc (WIDTH=8); MUL expectations follow PRELUDE_ALU_MUL_EN.
module tb_alu_mc;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [5:0]   alu_op = '0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out, out_hi;
    logic [3:0]   flags;

    typedef struct packed {
        logic [W-1:0] o;
        logic [W-1:0] hi;
        logic [3:0]   f;
    } resp_t;

    resp_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    bit    bp_en = 1'b0;
    bit    rdy_cmd = 1'b1;

    alu_mc #(.WIDTH(W), .OP_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_hi    (out_hi),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference: plain integer arithmetic on the values, signed views for V and SRA.
    function automatic resp_t model(int op, longint a, longint b);
        resp_t  r;
        longint m, res, hi, sa, sb, p, q;
        bit     c, v;
        m   = longint'(1) << W;
        sa  = a >= m / 2 ? a - m : a;
        sb  = b >= m / 2 ? b - m : b;
        res = 0;
        hi  = 0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            0: res = a | b;
            1: res = (m - 1) - (a & b);
            2: res = (m - 1) - (a | b);
            3: res = a & b;
            4: begin
                res = (a + b) % m;
                c   = (a + b) >= m;
                v   = (sa + sb) >= m / 2 || (sa + sb) < -(m / 2);
            end
            5: begin
                res = (a - b + m) % m;
                c   = a < b;
                v   = (sa - sb) >= m / 2 || (sa - sb) < -(m / 2);
            end
            6: res = a ^ b;
            7: res = b >= W ? 0 : (a * (longint'(1) << b)) % m;
            8: res = b >= W ? 0 : a / (longint'(1) << b);
            9: begin
                if (b >= W) res = sa < 0 ? m - 1 : 0;
                else begin
                    p = longint'(1) << b;
                    q = sa / p;
                    if (sa < 0 && sa % p != 0) q = q - 1;
                    res = (q + m) % m;
                end
            end
`ifdef PRELUDE_ALU_MUL_EN
            10: begin
                res = (a * b) % m;
                hi  = (a * b) / m;
                c   = hi != 0;
            end
`endif
            default: res = 0;
        endcase
        r.o  = res[W-1:0];
        r.hi = hi[W-1:0];
        r.f  = {res == 0, res >= m / 2, c, v};
        return r;
    endfunction

    task automatic issue(int op, logic [W-1:0] a, logic [W-1:0] b);
        int n = 0;
        @(negedge clk);
        out_ready = bp_en ? ($urandom_range(0, 3) != 0) : rdy_cmd;
        in_valid  = 1'b1;
        alu_op    = op[5:0];
        in_a      = a;
        in_b      = b;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            out_ready = bp_en ? ($urandom_range(0, 3) != 0) : rdy_cmd;
            #1;
            n++;
        end
        if (!in_ready) begin
            fail("issue_in_ready");
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called right after issue(): counts edges past the accept edge until out_valid, and busy cycles.
    task automatic lat(string name, int exp_edges);
        int k = 0;
        int low = 0;
        while (!out_valid && k < 100) begin
            if (!in_ready) low++;
            @(posedge clk);
            #1;
            k++;
        end
        chk({name, "_latency"}, k, exp_edges);
        chk({name, "_busy_cycles"}, low, exp_edges);
    endtask

    // Monitor: whenever the DUT presents a result it must match the oldest outstanding expectation.
    always @(negedge clk) begin
        resp_t e;
        #2;
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got out=%0h with no outstanding request", out);
            end else begin
                e = exp_q[0];
                chk("out", out, e.o);
                chk("out_hi", out_hi, e.hi);
                chk("flags", flags, e.f);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int mul_lat;
        int n;
        logic [W-1:0] ra, rb;
`ifdef PRELUDE_ALU_MUL_EN
        mul_lat = W;
`else
        mul_lat = 0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out", out, 0);
        chk("rst_out_hi", out_hi, 0);
        chk("rst_flags", flags, 0);

        issue(4, 8'hFF, 8'h01);
        lat("add", 0);
        chk("add_flags_direct", flags, 4'b1010);
        issue(5, 8'h80, 8'h01);
        issue(5, 8'h01, 8'h02);
        issue(9, 8'h90, 8'h02);
        issue(7, 8'h01, 8'h08);
        issue(8, 8'h80, 8'h09);
        issue(9, 8'h40, 8'hC8);
        issue(10, 8'hFF, 8'hFF);
        lat("mul", mul_lat);
        issue(63, 8'h12, 8'h34);
        issue(1, 8'hF0, 8'h3C);
        issue(2, 8'h00, 8'h00);

        // Backpressure: result held while the consumer stalls, then replaced back-to-back.
        repeat (3) @(negedge clk);
        rdy_cmd = 1'b0;
        issue(4, 8'h03, 8'h04);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_held_out", out, 8'h07);
        end
        rdy_cmd = 1'b1;
        issue(6, 8'hF0, 8'h0F);
        chk("bp_valid_stays", out_valid, 1);

        // Reset in the middle of an outstanding operation discards it.
        repeat (3) @(negedge clk);
`ifdef PRELUDE_ALU_MUL_EN
        issue(10, 8'h12, 8'h34);
`else
        rdy_cmd = 1'b0;
        issue(4, 8'h05, 8'h06);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out", out, 0);
        rdy_cmd = 1'b1;
        issue(4, 8'h01, 8'h01);
        lat("post_rst_add", 0);

        bp_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ra = W'($urandom);
            rb = $urandom_range(0, 2) == 0 ? W'($urandom_range(0, 10)) : W'($urandom);
            issue(int'($urandom_range(0, 12)), ra, rb);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        bp_en = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("drain_outstanding", exp_q.size(), 0);
        chk("drain_out_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
